// File: rtl/data_lsu_pkg.sv
// ---- data_lsu_pkg : shared types and sizing helpers for data_lsu (rev 1.0) ----
`default_nettype none

package data_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic REGION_SHARED = 1'b1;

  // One width serves both timers so a single sub-module covers latency and timeout.
  function automatic int cnt_width(input int mem_lat, input int arb_timeout);
    int m;
    m = (mem_lat > arb_timeout) ? mem_lat : arb_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_lsu_if.sv
// ---- data_lsu_if : pipeline, memory and arbiter signals of one core's LSU (rev 1.0) ----
`default_nettype none

interface data_lsu_if #(
  parameter int TAM = 16
) ();

  logic           cpu_req;
  logic           cpu_we;
  logic [0:TAM-1] cpu_addr;
  logic [0:TAM-1] cpu_wdata;
  logic           cpu_busy;
  logic           cpu_done;
  logic           cpu_rvalid;
  logic           cpu_err;
  logic [0:TAM-1] cpu_rdata;
  logic [0:TAM-1] dataADDR;
  logic [0:TAM-1] dataIN;
  logic           dataWrite;
  logic           dataLoad;
  logic [0:TAM-1] dataOUT;
  logic           shared_req;
  logic           shared_gnt;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dataOUT, shared_gnt,
    output cpu_busy, cpu_done, cpu_rvalid, cpu_err, cpu_rdata,
           dataADDR, dataIN, dataWrite, dataLoad, shared_req
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dataOUT, shared_gnt,
    input  cpu_busy, cpu_done, cpu_rvalid, cpu_err, cpu_rdata,
           dataADDR, dataIN, dataWrite, dataLoad, shared_req
  );

endinterface

`default_nettype wire

// File: rtl/data_lsu_timer.sv
// ---- lsu_timer : loadable up/down counter with a compare-to-TERM flag (rev 1.0) ----
`default_nettype none

module lsu_timer #(
  parameter int W    = 4,
  parameter int TERM = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr_i,
  input  wire logic         load_i,
  input  wire logic [W-1:0] load_val_i,
  input  wire logic         inc_i,
  input  wire logic         dec_i,
  output logic              tc_o
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = load_val_i;
    else if (inc_i)  count_d = count_q + 1'b1;
    else if (dec_i)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign tc_o = (count_q == TERM_V);

endmodule

`default_nettype wire

// File: rtl/data_lsu.sv
// ---- data_lsu : per-core load/store initiator with shared-region arbitration (rev 1.0) ----
`default_nettype none

module data_lsu
  import data_lsu_pkg::*;
#(
  parameter int TAM         = 16,
  parameter int Lmem        = 8,
  parameter int MEM_LAT     = 1,
  parameter int ARB_TIMEOUT = 15
) (
  input  wire logic   clk,
  input  wire logic   rst,
  data_lsu_if.master  bus
);

  localparam int             CW    = cnt_width(MEM_LAT, ARB_TIMEOUT);
  localparam logic [CW-1:0]  LAT_V = CW'(MEM_LAT);

  state_e         state_q, state_d;
  logic [0:TAM-1] addr_q, addr_d;
  logic [0:TAM-1] wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [0:TAM-1] rdata_q, rdata_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rvalid_q, rvalid_d;
  logic           err_q, err_d;
  logic [0:TAM-1] maddr_q, maddr_d;
  logic [0:TAM-1] mdin_q, mdin_d;
  logic           mwr_q, mwr_d;
  logic           mld_q, mld_d;
  logic           sreq_q, sreq_d;
  logic           lat_tc;
  logic           tmo_tc;

  // Counts ARB cycles from 0; terminal on the ARB_TIMEOUT-th cycle.
  lsu_timer #(.W(CW), .TERM(ARB_TIMEOUT - 1)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != ARB),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (state_q == ARB),
    .dec_i      (1'b0),
    .tc_o       (tmo_tc)
  );

  // Loaded in ISSUE; terminal in the last WAIT cycle, when dataOUT is valid.
  lsu_timer #(.W(CW), .TERM(1)) u_lat (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (1'b0),
    .load_i     (state_q == ISSUE),
    .load_val_i (LAT_V),
    .inc_i      (1'b0),
    .dec_i      (state_q == WAIT),
    .tc_o       (lat_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    maddr_d  = '0;
    mdin_d   = '0;
    mwr_d    = 1'b0;
    mld_d    = 1'b0;
    sreq_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_we;
          state_d = (bus.cpu_addr[Lmem] == REGION_SHARED) ? ARB : ISSUE;
        end
      end
      ARB: begin
        if (bus.shared_gnt) begin
          state_d = ISSUE;
        end else if (tmo_tc) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT: begin
        if (lat_tc) begin
          rdata_d = bus.dataOUT;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      ARB: begin
        busy_d = 1'b1;
        sreq_d = 1'b1;
      end
      ISSUE: begin
        busy_d  = 1'b1;
        sreq_d  = (addr_d[Lmem] == REGION_SHARED);
        maddr_d = addr_d;
        mwr_d   = we_d;
        mld_d   = ~we_d;
        mdin_d  = we_d ? wdata_d : '0;
      end
      WAIT: begin
        busy_d  = 1'b1;
        sreq_d  = (addr_d[Lmem] == REGION_SHARED);
        maddr_d = addr_d;
      end
      DONE: begin
        done_d   = 1'b1;
        rvalid_d = ~we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      mwr_q    <= 1'b0;
      mld_q    <= 1'b0;
      sreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      mwr_q    <= mwr_d;
      mld_q    <= mld_d;
      sreq_q   <= sreq_d;
    end
  end

  assign bus.cpu_busy   = busy_q;
  assign bus.cpu_done   = done_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_err    = err_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.dataADDR   = maddr_q;
  assign bus.dataIN     = mdin_q;
  assign bus.dataWrite  = mwr_q;
  assign bus.dataLoad   = mld_q;
  assign bus.shared_req = sreq_q;

endmodule

`default_nettype wire

// File: doc/data_lsu.md
Name: data_lsu

Overview:
- Per-core load/store initiator that drives the core side of the multi-core data memory.
- Inputs: one load or store request at a time from the pipeline.
- Decodes the private/shared region and arbitrates for shared space.
- Issues a one-cycle memory strobe, waits the fixed read latency, then returns data and stall/done status to the pipeline.
- One instance per core; its outputs feed that core's slot of the memory's dataADDR/dataIN/dataWrite/dataLoad arrays.

Parameters:
- TAM, 16, data and address width.
- Lmem, 8, private/shared region bit index in address; also private address width.
- MEM_LAT, 1, cycles from the dataLoad cycle to dataOUT valid; must be >= 1.
- ARB_TIMEOUT, 15, maximum cycles waiting for shared_gnt before abort; must be >= 1.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  pipeline request strobe; sampled only when cpu_busy=0.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  TAM  request address; bit [Lmem] = 1 selects shared, 0 selects private.
- cpu_wdata  in  TAM  store data.
- cpu_busy  out  1  stall to pipeline.
- cpu_done  out  1  one-cycle completion pulse, loads and stores.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid (loads only).
- cpu_err  out  1  one-cycle pulse; shared arbitration timed out, request dropped.
- cpu_rdata  out  TAM  load result; holds until the next load completes.
- dataADDR  out  TAM  memory address.
- dataIN  out  TAM  memory write data.
- dataWrite  out  1  memory write strobe.
- dataLoad  out  1  memory read strobe.
- dataOUT  in  TAM  memory read data.
- shared_req  out  1  request for the shared-memory arbiter.
- shared_gnt  in  1  grant from the shared-memory arbiter.

Behaviour:
- Vectors declared [0:TAM-1]; region bit is addr[Lmem] in that numbering.
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 including cpu_rdata and shared_req; counters 0.
- All outputs are registered; memory-side signals are stable for whole cycles, so a store commits at the rising edge ending its dataWrite cycle.
- FSM states: IDLE, ARB, ISSUE, WAIT, DONE.
- IDLE: cpu_busy=0.
  - On cpu_req=1, latch addr, we and wdata.
  - Next state is ARB if addr[Lmem]=1, else ISSUE.
- ARB: cpu_busy=1, shared_req=1; timeout counter increments each cycle.
  - shared_gnt=1 sampled: go to ISSUE.
  - Counter reaching ARB_TIMEOUT without grant: cpu_err pulse, shared_req drops, return to IDLE; no memory strobe.
  - Grant and timeout in the same cycle: grant wins.
- ISSUE: exactly one cycle; cpu_busy=1.
  - dataADDR=addr, dataWrite=we, dataLoad=~we; dataIN=wdata for stores, 0 for loads.
  - shared_req stays 1 for shared accesses.
  - Next state: DONE for a store; WAIT for a load, with the latency counter loaded to MEM_LAT.
- WAIT: cpu_busy=1; dataADDR held at addr; strobes 0.
  - Latency counter decrements each cycle.
  - dataOUT is captured into cpu_rdata at the rising edge ending the MEM_LAT-th cycle after ISSUE, then go to DONE.
- DONE: one cycle; cpu_busy=0; shared_req=0; memory-side outputs 0.
  - cpu_done=1; cpu_rvalid=1 for loads.
  - A cpu_req in DONE is accepted exactly as in IDLE (back-to-back).
- Latency from the accept cycle N, MEM_LAT=1:
  - Private store: done at N+2.
  - Private load: rvalid at N+3.
  - Shared access: add the ARB cycles (>= 1).
- cpu_req while busy: ignored; the pipeline must hold it.
- shared_gnt outside ARB: ignored.
- Reset mid-operation: immediate return to reset values; a store already committed stays committed.

Decomposition:
- Package data_lsu_pkg:
  - state enum (IDLE, ARB, ISSUE, WAIT, DONE);
  - REGION_SHARED=1'b1;
  - counter width function clog2(max(MEM_LAT, ARB_TIMEOUT)+1).
- One sub-module, lsu_timer: loadable up/down counter with terminal flag, instantiated once each for latency and timeout.

Test Plan:
- Private store: cpu_req, we=1, addr=0x0012, wdata=0xBEEF → dataWrite=1 for exactly one cycle with dataADDR=0x0012 and dataIN=0xBEEF; cpu_done at N+2; shared_req stays 0.
- Private load, MEM_LAT=1: model returns 0x1234 at 0x0012 → dataLoad for one cycle; cpu_rvalid at N+3 with cpu_rdata=0x1234; cpu_busy=1 for N+1..N+2.
- Shared load at 0x0080 (bit[8]=1 with TAM=16), grant after 3 cycles → shared_req high from N+1 through the WAIT cycle; ISSUE one cycle after the grant is sampled; data returned correctly.
- Arbitration timeout, ARB_TIMEOUT=4, gnt held 0 → cpu_err pulses once after 4 ARB cycles; no dataWrite/dataLoad; shared_req drops; the next private request succeeds.
- Back-to-back: cpu_req held high for 4 alternating store/load requests → each request accepted in its DONE cycle; no idle gap; all results correct.
- Reset mid-WAIT: assert rst=0 asynchronously between edges → all outputs 0 immediately; no rvalid after release; FSM in IDLE.
